// File: rtl/pid_mux_iter.sv
// pid_mux_iter
// Time-multiplexed incremental PID controller. One signed Width x Width
// multiplier is shared by NCH independent loops. Each sample walks a fixed
// seven-cycle sequence: IDLE -> ERR -> MAC0 -> MAC1 -> MAC2 -> SCALE -> CLAMP.
// Each channel keeps its last two errors (e1, e2) and its output u.
//
// Ports
//   i_clkp, i_rstn        clock, asynchronous active-low reset
//   i_valid / o_ready     sample handshake (o_ready high only in IDLE)
//   i_ch, i_rt, i_yt      channel, setpoint, measurement (captured on accept)
//   i_hold                process the sample but keep u and the error history
//   i_k0, i_k1, i_k2      incremental coefficients
//   i_shift               rounding right-shift applied to the increment
//   i_min, i_max          output limits (both zero = no limiting)
//   i_clr, i_clr_ch       zero the state of one channel
//   o_valid               one-cycle result strobe
//   o_ch, o_ut, o_sat     result channel, control output, clamped flag (held)
module pid_mux_iter #(
    parameter int Width = 16,
    parameter int NCH   = 4,
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int Shift = 5
) (
    input  logic                 i_clkp,
    input  logic                 i_rstn,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [CW-1:0]        i_ch,
    input  logic [Width-1:0]     i_rt,
    input  logic [Width-1:0]     i_yt,
    input  logic                 i_hold,
    input  logic [Width-1:0]     i_k0,
    input  logic [Width-1:0]     i_k1,
    input  logic [Width-1:0]     i_k2,
    input  logic [Shift-1:0]     i_shift,
    input  logic [2*Width-1:0]   i_min,
    input  logic [2*Width-1:0]   i_max,
    input  logic                 i_clr,
    input  logic [CW-1:0]        i_clr_ch,
    output logic                 o_valid,
    output logic [CW-1:0]        o_ch,
    output logic [2*Width-1:0]   o_ut,
    output logic                 o_sat
);
    localparam int UW = 2 * Width;      // output / u width
    localparam int AW = 2 * Width + 2;  // accumulator width
    localparam int VW = 2 * Width + 3;  // u + increment width

    localparam logic signed [VW-1:0] V_UMAX = {{(VW-UW+1){1'b0}}, {(UW-1){1'b1}}};
    localparam logic signed [VW-1:0] V_UMIN = {{(VW-UW+1){1'b1}}, {(UW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MAC0, S_MAC1, S_MAC2, S_SCALE, S_CLAMP
    } state_t;

    state_t                   state_reg;
    logic                     ready_reg, valid_reg, sat_reg;
    logic [CW-1:0]            och_reg;
    logic [UW-1:0]            ut_reg;

    // Captured sample
    logic [CW-1:0]            ch_reg;
    logic signed [Width-1:0]  rt_reg, yt_reg, k0_reg, k1_reg, k2_reg;
    logic                     hold_reg;
    logic [Shift-1:0]         shift_reg;
    logic signed [UW-1:0]     min_reg, max_reg;

    // Datapath pipeline registers
    logic signed [Width-1:0]  e0_reg;
    logic signed [AW-1:0]     acc_reg;
    logic signed [VW-1:0]     v_reg;

    // Per-channel state
    logic signed [Width-1:0]  e1_mem [NCH];
    logic signed [Width-1:0]  e2_mem [NCH];
    logic signed [UW-1:0]     u_mem  [NCH];

    logic                     ch_ok, wb_en;
    logic signed [Width-1:0]  e1_cur, e2_cur;
    logic signed [UW-1:0]     u_cur;
    logic signed [Width:0]    diff;
    logic signed [Width-1:0]  e0_next;
    logic signed [Width-1:0]  mul_a, mul_b;
    logic signed [UW-1:0]     prod;
    logic signed [AW-1:0]     prod_ext;
    logic signed [VW-1:0]     acc_ext, half, du, u_ext, v_next, min_ext, max_ext;
    logic [UW-1:0]            res_next;
    logic                     sat_next;

    assign o_ready = ready_reg;
    assign o_valid = valid_reg;
    assign o_ch    = och_reg;
    assign o_ut    = ut_reg;
    assign o_sat   = sat_reg;

    // Channels beyond NCH are processed but never touch the state arrays.
    assign ch_ok = ({1'b0, ch_reg} < (CW+1)'(NCH));
    assign wb_en = (state_reg == S_CLAMP) && ch_ok && !hold_reg;

    always_comb begin
        e1_cur = '0;
        e2_cur = '0;
        u_cur  = '0;
        if (ch_ok) begin
            e1_cur = e1_mem[ch_reg];
            e2_cur = e2_mem[ch_reg];
            u_cur  = u_mem[ch_reg];
        end
    end

    // Error in Width+1 bits, saturated back to Width.
    assign diff = {rt_reg[Width-1], rt_reg} - {yt_reg[Width-1], yt_reg};
    always_comb begin
        e0_next = diff[Width-1:0];
        if (diff[Width] != diff[Width-1])
            e0_next = diff[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end

    // Single shared multiplier; operands selected by the MAC phase.
    always_comb begin
        mul_a = k0_reg;
        mul_b = e0_reg;
        case (state_reg)
            S_MAC1: begin mul_a = k1_reg; mul_b = e1_cur; end
            S_MAC2: begin mul_a = k2_reg; mul_b = e2_cur; end
            default: ;
        endcase
    end
    assign prod     = mul_a * mul_b;
    assign prod_ext = {{2{prod[UW-1]}}, prod};

    // Round half toward +inf: add 2^(shift-1) before the arithmetic shift.
    assign acc_ext = {acc_reg[AW-1], acc_reg};
    assign half    = (shift_reg == '0) ? '0 : (VW'(1) << (shift_reg - 1'b1));
    assign du      = (acc_ext + half) >>> shift_reg;
    assign u_ext   = {{(VW-UW){u_cur[UW-1]}}, u_cur};
    assign v_next  = u_ext + du;

    assign min_ext = {{(VW-UW){min_reg[UW-1]}}, min_reg};
    assign max_ext = {{(VW-UW){max_reg[UW-1]}}, max_reg};

    always_comb begin
        res_next = v_reg[UW-1:0];
        sat_next = 1'b0;
        if (!ch_ok) begin
            res_next = '0;
        end else if (hold_reg) begin
            res_next = u_cur;
        end else if (min_reg == '0 && max_reg == '0) begin
            if (v_reg > V_UMAX) begin
                res_next = V_UMAX[UW-1:0];
                sat_next = 1'b1;
            end else if (v_reg < V_UMIN) begin
                res_next = V_UMIN[UW-1:0];
                sat_next = 1'b1;
            end
        end else if (min_reg >= max_reg) begin
            res_next = '0;
            sat_next = 1'b1;
        end else if (v_reg < min_ext) begin
            res_next = min_reg;
            sat_next = 1'b1;
        end else if (v_reg > max_ext) begin
            res_next = max_reg;
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            och_reg   <= '0;
            ut_reg    <= '0;
            sat_reg   <= 1'b0;
            ch_reg    <= '0;
            rt_reg    <= '0;
            yt_reg    <= '0;
            k0_reg    <= '0;
            k1_reg    <= '0;
            k2_reg    <= '0;
            hold_reg  <= 1'b0;
            shift_reg <= '0;
            min_reg   <= '0;
            max_reg   <= '0;
            e0_reg    <= '0;
            acc_reg   <= '0;
            v_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (i_valid) begin
                    ch_reg    <= i_ch;
                    rt_reg    <= i_rt;
                    yt_reg    <= i_yt;
                    hold_reg  <= i_hold;
                    k0_reg    <= i_k0;
                    k1_reg    <= i_k1;
                    k2_reg    <= i_k2;
                    shift_reg <= i_shift;
                    min_reg   <= i_min;
                    max_reg   <= i_max;
                    ready_reg <= 1'b0;
                    state_reg <= S_ERR;
                end
                S_ERR: begin
                    e0_reg    <= e0_next;
                    state_reg <= S_MAC0;
                end
                S_MAC0: begin
                    acc_reg   <= prod_ext;
                    state_reg <= S_MAC1;
                end
                S_MAC1: begin
                    acc_reg   <= acc_reg + prod_ext;
                    state_reg <= S_MAC2;
                end
                S_MAC2: begin
                    acc_reg   <= acc_reg + prod_ext;
                    state_reg <= S_SCALE;
                end
                S_SCALE: begin
                    v_reg     <= v_next;
                    state_reg <= S_CLAMP;
                end
                S_CLAMP: begin
                    valid_reg <= 1'b1;
                    och_reg   <= ch_reg;
                    ut_reg    <= res_next;
                    sat_reg   <= sat_next;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Channel state; a clear on the same edge as writeback wins.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            always_ff @(posedge i_clkp or negedge i_rstn) begin
                if (!i_rstn) begin
                    e1_mem[gi] <= '0;
                    e2_mem[gi] <= '0;
                    u_mem[gi]  <= '0;
                end else if (i_clr && i_clr_ch == CW'(gi)) begin
                    e1_mem[gi] <= '0;
                    e2_mem[gi] <= '0;
                    u_mem[gi]  <= '0;
                end else if (wb_en && ch_reg == CW'(gi)) begin
                    u_mem[gi]  <= res_next;
                    e2_mem[gi] <= e1_mem[gi];
                    e1_mem[gi] <= e0_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pid_mux_iter.sv
// Bench for pid_mux_iter: directed samples with literal expectations plus a
// randomized stream checked every cycle against a behavioural model.
module tb_pid_mux_iter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int SH = 5;
    localparam longint UMAX = 64'sd2147483647;
    localparam longint UMIN = -64'sd2147483648;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [CW-1:0]   i_ch = '0;
    logic [W-1:0]    i_rt = '0, i_yt = '0, i_k0 = '0, i_k1 = '0, i_k2 = '0;
    logic            i_hold = 1'b0;
    logic [SH-1:0]   i_shift = '0;
    logic [2*W-1:0]  i_min = '0, i_max = '0;
    logic            i_clr = 1'b0;
    logic [CW-1:0]   i_clr_ch = '0;
    logic            o_valid;
    logic [CW-1:0]   o_ch;
    logic [2*W-1:0]  o_ut;
    logic            o_sat;

    pid_mux_iter #(.Width(W), .NCH(N), .CW(CW), .Shift(SH)) dut (
        .i_clkp(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_ch(i_ch), .i_rt(i_rt), .i_yt(i_yt), .i_hold(i_hold),
        .i_k0(i_k0), .i_k1(i_k1), .i_k2(i_k2), .i_shift(i_shift),
        .i_min(i_min), .i_max(i_max), .i_clr(i_clr), .i_clr_ch(i_clr_ch),
        .o_valid(o_valid), .o_ch(o_ch), .o_ut(o_ut), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch, rt, yt;
        bit     hold;
        int     k0, k1, k2, sh;
        longint mn, mx;
    } txn_t;

    typedef struct {
        time    due;
        longint ut, ch, sat;
    } exp_t;

    exp_t   q[$];
    longint mu [N];
    longint me1[N];
    longint me2[N];
    longint last_ut = 0, last_ch = 0, last_sat = 0;
    time    acc_t = 0;
    bit     have_acc = 1'b0;
    int     n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input longint act, input longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic txn_t mk(input int ch, rt, yt, k0, k1, k2, sh,
                                input longint mn, mx, input bit hold);
        txn_t t;
        t.ch = ch; t.rt = rt; t.yt = yt; t.k0 = k0; t.k1 = k1; t.k2 = k2;
        t.sh = sh; t.mn = mn; t.mx = mx; t.hold = hold;
        return t;
    endfunction

    function automatic void model_clear(input int c);
        if (c < N) begin mu[c] = 0; me1[c] = 0; me2[c] = 0; end
    endfunction

    // Incremental PID with plain integer arithmetic.
    function automatic void model(input txn_t t, output longint r, output bit s);
        longint e0, acc, du, v;
        e0 = longint'(t.rt) - longint'(t.yt);
        if (e0 > 32767) e0 = 32767;
        if (e0 < -32768) e0 = -32768;
        r = 0;
        s = 1'b0;
        if (t.ch >= N) return;
        if (t.hold) begin r = mu[t.ch]; return; end
        acc = longint'(t.k0) * e0 + longint'(t.k1) * me1[t.ch] + longint'(t.k2) * me2[t.ch];
        if (t.sh == 0) du = acc;
        else du = (acc + (longint'(1) << (t.sh - 1))) >>> t.sh;
        v = mu[t.ch] + du;
        if (t.mn == 0 && t.mx == 0) begin
            if (v > UMAX) begin r = UMAX; s = 1'b1; end
            else if (v < UMIN) begin r = UMIN; s = 1'b1; end
            else r = v;
        end else if (t.mn >= t.mx) begin
            r = 0; s = 1'b1;
        end else if (v < t.mn) begin
            r = t.mn; s = 1'b1;
        end else if (v > t.mx) begin
            r = t.mx; s = 1'b1;
        end else r = v;
        mu[t.ch]  = r;
        me2[t.ch] = me1[t.ch];
        me1[t.ch] = e0;
    endfunction

    // Per-cycle compare, sampled 3 time units after each rising edge.
    initial begin
        bit   exp_v;
        exp_t e;
        @(posedge clk);
        forever begin
            @(posedge clk);
            #3;
            exp_v = (q.size() > 0) && (q[0].due == $time);
            check("o_valid", longint'(o_valid), longint'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                last_ut = e.ut; last_ch = e.ch; last_sat = e.sat;
            end
            check("o_ut", longint'($signed(o_ut)), last_ut);
            check("o_ch", longint'(o_ch), last_ch);
            check("o_sat", longint'(o_sat), last_sat);
            check("o_ready", longint'(o_ready), longint'(!(have_acc && $time < acc_t + 60)));
        end
    end

    // Starts at a falling edge and returns at a falling edge.
    task automatic send(input txn_t t, input int clr_ch, input int clr_k, input int rst_k,
                        output bit got, output longint r_ut, output bit r_sat,
                        output longint m_ut, output bit m_sat);
        bit rdy, accepted;
        int pend;
        got = 1'b0; r_ut = 0; r_sat = 1'b0; m_ut = 0; m_sat = 1'b0;
        accepted = 1'b0; pend = -1;
        i_ch = CW'(t.ch); i_rt = W'(t.rt); i_yt = W'(t.yt); i_hold = t.hold;
        i_k0 = W'(t.k0); i_k1 = W'(t.k1); i_k2 = W'(t.k2); i_shift = SH'(t.sh);
        i_min = t.mn[31:0]; i_max = t.mx[31:0];
        i_valid = 1'b1;
        for (int w = 0; w < 30; w++) begin
            rdy = o_ready;
            @(posedge clk);
            if (rdy) begin accepted = 1'b1; break; end
            @(negedge clk);
        end
        check("accept", longint'(accepted), 1);
        if (!accepted) begin i_valid = 1'b0; return; end
        acc_t = $time;
        have_acc = 1'b1;
        model(t, m_ut, m_sat);
        q.push_back('{due: $time + 63, ut: m_ut, ch: longint'(t.ch), sat: longint'(m_sat)});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble the inputs: the in-flight sample must not see them.
                i_valid = 1'b0;
                i_rt = W'($urandom); i_yt = W'($urandom); i_k0 = W'($urandom);
                i_k1 = W'($urandom); i_k2 = W'($urandom); i_shift = SH'($urandom);
                i_min = $urandom; i_max = $urandom; i_hold = 1'(($urandom));
                i_ch = CW'($urandom);
            end
            if (pend >= 0) begin i_clr = 1'b0; model_clear(pend); pend = -1; end
            if (k == clr_k) begin i_clr = 1'b1; i_clr_ch = CW'(clr_ch); pend = clr_ch; end
            if (k == rst_k) begin
                rstn = 1'b0;
                q.delete();
                have_acc = 1'b0;
                for (int c = 0; c < N; c++) model_clear(c);
                last_ut = 0; last_ch = 0; last_sat = 0;
            end
            if (rst_k > 0 && k == rst_k + 1) begin rstn = 1'b1; break; end
            if (o_valid) begin
                got = 1'b1;
                r_ut = longint'($signed(o_ut));
                r_sat = o_sat;
                break;
            end
        end
        if (rst_k < 0) check("strobe_seen", longint'(got), 1);
    endtask

    task automatic run(input txn_t t, input longint want, input bit wsat, input string name);
        bit got, r_sat, m_sat;
        longint r_ut, m_ut;
        send(t, -1, -1, -1, got, r_ut, r_sat, m_ut, m_sat);
        check({name, "_ut"}, r_ut, want);
        check({name, "_sat"}, longint'(r_sat), longint'(wsat));
        check({name, "_model"}, m_ut, want);
        $display("txn %s ch=%0d ut=%0d sat=%0d", name, t.ch, r_ut, r_sat);
    endtask

    task automatic idle_clear(input int c);
        i_clr = 1'b1;
        i_clr_ch = CW'(c);
        @(negedge clk);
        i_clr = 1'b0;
        model_clear(c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bit got, r_sat, m_sat;
        longint r_ut, m_ut;
        int lm, cc, ck;
        for (int c = 0; c < N; c++) model_clear(c);
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run(mk(0, 100, 40, 2, 0, 0, 0, 0, 0, 0), 120, 0, "ch0_first");
        run(mk(0, 100, 40, 2, 0, 0, 0, 0, 0, 0), 240, 0, "ch0_repeat");
        for (int i = 1; i <= 3; i++) begin
            run(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0), 10 * i, 0, "ch1_step");
            run(mk(2, 0, 5, 1, 0, 0, 0, 0, 0, 0), -5 * i, 0, "ch2_step");
        end
        run(mk(0, 50, 0, 1, 0, 0, 0, -20, 30, 0), 30, 1, "clamp_hi");
        run(mk(0, 0, 5, 1, 0, 0, 0, -20, 30, 0), 25, 0, "antiwindup");
        run(mk(1, 0, 1, 1, 0, 0, 2, 0, 0, 0), 30, 0, "round_m1");
        run(mk(1, 6, 0, 1, 0, 0, 2, 0, 0, 0), 32, 0, "round_p6");
        run(mk(1, 0, 6, 1, 0, 0, 2, 0, 0, 0), 31, 0, "round_m6");
        run(mk(3, 1, 0, 0, 3, 5, 0, 0, 0, 0), 0, 0, "hist_1");
        run(mk(3, 2, 0, 0, 3, 5, 0, 0, 0, 0), 3, 0, "hist_2");
        run(mk(3, 4, 0, 0, 3, 5, 0, 0, 0, 0), 14, 0, "hist_4");
        run(mk(3, 9, 0, 1, 0, 0, 0, 0, 0, 1), 14, 0, "hold");

        send(mk(3, 7, 0, 1, 0, 0, 0, 0, 0, 0), 3, 6, -1, got, r_ut, r_sat, m_ut, m_sat);
        check("clr_emit_ut", r_ut, 21);
        $display("txn clr_at_clamp ch=3 ut=%0d sat=%0d", r_ut, r_sat);
        run(mk(3, 2, 0, 1, 3, 5, 0, 0, 0, 0), 2, 0, "after_clr");
        run(mk(2, 1, 0, 1, 0, 0, 0, 10, 5, 0), 0, 1, "min_ge_max");

        send(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0), -1, -1, 3, got, r_ut, r_sat, m_ut, m_sat);
        check("rst_no_strobe", longint'(got), 0);
        $display("txn reset_mid_mac1 ch=1 strobe=%0d", got);
        run(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0), 10, 0, "after_reset");

        for (int n = 0; n < 200; n++) begin
            t.ch = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0) begin
                t.rt = int'($urandom_range(0, 65535)) - 32768;
                t.yt = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                t.rt = int'($urandom_range(0, 400)) - 200;
                t.yt = int'($urandom_range(0, 400)) - 200;
            end
            t.k0 = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 20)) - 10;
            t.k1 = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 20)) - 10;
            t.k2 = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 20)) - 10;
            t.sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
            t.hold = ($urandom_range(0, 9) == 0);
            lm = $urandom_range(0, 3);
            case (lm)
                0: begin t.mn = 0; t.mx = 0; end
                1: begin t.mn = -longint'($urandom_range(0, 5000)); t.mx = longint'($urandom_range(1, 5000)); end
                2: begin t.mx = longint'($urandom_range(0, 2000)) - 1000; t.mn = t.mx + longint'($urandom_range(0, 100)); end
                default: begin t.mn = longint'(int'($urandom)); t.mx = longint'(int'($urandom)); end
            endcase
            if ($urandom_range(0, 7) == 0) idle_clear($urandom_range(0, N - 1));
            cc = -1; ck = -1;
            if ($urandom_range(0, 5) == 0) begin
                cc = $urandom_range(0, N - 1);
                ck = (cc == t.ch) ? 6 : int'($urandom_range(1, 6));
            end
            send(t, cc, ck, -1, got, r_ut, r_sat, m_ut, m_sat);
            $display("txn rnd%0d ch=%0d ut=%0d sat=%0d model=%0d/%0d", n, t.ch, r_ut, r_sat, m_ut, m_sat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("drain", longint'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
